// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
//   state_e  : detector FSM states (DIS, FILL, ARMED)
//   len_w()  : width of a field that can hold 0..max_len
//   sat_inc(): increment that stops at a limit instead of wrapping
package seq_detect_pkg;

  typedef enum logic [1:0] {
    DIS   = 2'd0,  // no valid configuration loaded
    FILL  = 2'd1,  // fewer than cfg_len bits collected since last clear
    ARMED = 2'd2   // history full, compare on every accepted bit
  } state_e;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (count -> 0)
//   inc   : increment by one this edge (holds at 2^W-1)
//   clr   : clear to zero this edge (wins over inc)
//   count : current count
module seq_sat_counter
  import seq_detect_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [31:0] LIMIT = 32'((64'd1 << W) - 64'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= W'(sat_inc(32'(count), LIMIT));
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector.
// A pattern of 1..MAX_LEN bits is loaded with cfg_load; accepted input bits
// shift into a history register and a registered one-cycle pulse is emitted
// on seq_seen for each match. Overlapping or non-overlapping detection is
// selectable; matches are counted in a saturating counter.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   inp_bit      : serial data bit, sampled only when inp_valid is high
//   inp_valid    : input qualifier
//   cfg_load     : latch pattern/pat_len/overlap_en; clears detection state
//   pattern      : pattern[pat_len-1] is the first bit, pattern[0] the last
//   pat_len      : pattern length; 0 or > MAX_LEN disables detection
//   overlap_en   : 1 = overlapping, 0 = restart after each match
//   seq_seen     : one-cycle match pulse (registered)
//   match_count  : saturating count of matches since last load/reset
//   active       : a valid configuration is loaded
//   last_gap     : (only with SEQ_DETECT_LAST_MATCH_EN defined) accepted bits
//                  strictly between the last two matches, saturating
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inp_bit,
  input  logic                       inp_valid,
  input  logic                       cfg_load,
  input  logic [MAX_LEN-1:0]         pattern,
  input  logic [len_w(MAX_LEN)-1:0]  pat_len,
  input  logic                       overlap_en,
  output logic                       seq_seen,
  output logic [CNT_W-1:0]           match_count,
  output logic                       active
`ifdef SEQ_DETECT_LAST_MATCH_EN
  ,
  output logic [CNT_W-1:0]           last_gap
`endif
);

  localparam int LEN_W = len_w(MAX_LEN);

  state_e             state, state_next;
  logic [MAX_LEN-1:0] cfg_pat, hist, hist_next, hist_d, len_mask;
  logic [LEN_W-1:0]   cfg_len, fill, fill_next, fill_d;
  logic               cfg_ovl, len_ok, accepted, match;

  assign len_ok    = (pat_len != '0) && (int'(pat_len) <= MAX_LEN);
  // A load edge ignores data; DIS never accepts bits.
  assign accepted  = inp_valid && !cfg_load && (state != DIS);
  assign hist_next = {hist[MAX_LEN-2:0], inp_bit};
  assign fill_next = LEN_W'(sat_inc(32'(fill), 32'(cfg_len)));

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(cfg_len));
    end
  end

  assign match = accepted && (fill_next >= cfg_len) &&
                 (((hist_next ^ cfg_pat) & len_mask) == '0);

  always_comb begin
    state_next = state;
    hist_d     = hist;
    fill_d     = fill;
    if (cfg_load) begin
      state_next = len_ok ? FILL : DIS;
      hist_d     = '0;
      fill_d     = '0;
    end else if (accepted) begin
      hist_d = hist_next;
      fill_d = fill_next;
      if (match && !cfg_ovl) begin
        // Non-overlapping: the matched bits may not start the next match.
        hist_d     = '0;
        fill_d     = '0;
        state_next = FILL;
      end else if (fill_next >= cfg_len) begin
        state_next = ARMED;
      end else begin
        state_next = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DIS;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: history is a flop-based shift register, not a RAM, so it takes the
  // async reset along with the rest of the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist     <= '0;
      fill     <= '0;
      cfg_pat  <= '0;
      cfg_len  <= '0;
      cfg_ovl  <= 1'b0;
      seq_seen <= 1'b0;
    end else begin
      hist     <= hist_d;
      fill     <= fill_d;
      seq_seen <= match;
      if (cfg_load) begin
        cfg_pat <= pattern;
        cfg_len <= pat_len;
        cfg_ovl <= overlap_en;
      end
    end
  end

  assign active = (state != DIS);

  seq_sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (cfg_load),
    .count (match_count)
  );

`ifdef SEQ_DETECT_LAST_MATCH_EN
  // Accepted bits since the previous match; captured into last_gap on a
  // match, but only once a previous match exists to measure from.
  logic [CNT_W-1:0] gap_run;
  logic             have_match;

  seq_sat_counter #(.W(CNT_W)) u_gap_run (
    .clk   (clk),
    .reset (reset),
    .inc   (accepted && !match),
    .clr   (cfg_load || match),
    .count (gap_run)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gap   <= '0;
      have_match <= 1'b0;
    end else if (cfg_load) begin
      last_gap   <= '0;
      have_match <= 1'b0;
    end else if (match) begin
      have_match <= 1'b1;
      if (have_match) begin
        last_gap <= gap_run;
      end
    end
  end
`endif

endmodule
